move_controller: RTL and testbench
==================================

Name: move_controller

Overview:
- Upstream sequencer for the 10x10x2 board RAM in the ultimate tic-tac-toe design.
- Accepts one move request (macro, micro) at a time. Validates it against the game rules and the RAM contents, then writes the move into the RAM.
- Reads back the macro-cell result. When a macro cell is won, it records the winner in macro 0 (the global board) and evaluates the global result.
- Tracks current player, forced macro and game end; sits between the input/UI FSM and the board RAM.

Parameters:
- none (board geometry fixed: macros 1..9 playable, macro 0 = global board, micros 1..9)

Ports:
- clk  in  1  system clock, all state on rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  move request strobe, sampled only in IDLE
- new_game  in  1  restart strobe, sampled only in IDLE, priority over start
- macro_in  in  4  requested macro cell (valid 1..9)
- micro_in  in  4  requested micro cell (valid 1..9)
- ram_q  in  2  RAM read data, 1 cycle after address
- ram_state  in  2  RAM result of addressed macro: 00 running, 01 P1, 10 P2, 11 draw
- ram_we  out  1  RAM write enable
- ram_data  out  2  RAM write data
- ram_addr_macro  out  4  RAM macro address
- ram_addr_micro  out  4  RAM micro address
- ram_clear  out  1  active-high clear pulse to RAM
- player  out  2  player to move: 01 or 10
- forced_macro  out  4  macro the next move must use; 0 = free choice
- closed_mask  out  9  bit k-1 set = macro k finished (won or drawn)
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse: move accepted and fully evaluated
- invalid  out  1  1-cycle pulse: move or request rejected
- game_over  out  1  high once game finished, until new_game
- winner  out  2  00 none, 01 P1, 10 P2, 11 global draw

Behaviour:
- Reset (clear_n=0, async): state=IDLE, player=01, forced_macro=0, closed_mask=0, game_over=0, winner=00, busy/done/invalid/ram_we/ram_clear=0. Address outputs 0. Deasserting ram_we must not wait for a clock edge.
- Address mux: regs latched on start (m, u). In G* states addr={0,m}; in all other states addr={m,u}. Addresses are held constant from LOOKUP through EVAL.
- IDLE:
  - new_game=1 -> ram_clear=1 for one cycle and all game registers return to reset values; stay IDLE.
  - else start=1 and game_over=1 -> REJECT.
  - else start=1 -> latch macro_in/micro_in into m/u, go to LOOKUP.
  - start while busy is ignored, not queued.
- LOOKUP: present address; the RAM registers it.
- CHECK: ram_q is valid. The move is invalid if any of: m or u outside 1..9; forced_macro!=0 and m!=forced_macro; closed_mask[m-1]=1; ram_q!=00. Invalid -> REJECT; valid -> WRITE.
- REJECT: invalid=1 for one cycle, then IDLE. No change to player, forced_macro, mask or RAM.
- WRITE: ram_we=1, ram_data=player, one cycle only.
- WAIT: RAM recomputes state from the new contents.
- EVAL: sample ram_state.
  - 00: no mask change.
  - 11: set closed_mask[m-1].
  - 01/10: set closed_mask[m-1], go to GWRITE.
  - Otherwise go to FINISH.
- GWRITE: ram_we=1, addr={0,m}, ram_data=macro winner. Then GWAIT, then GEVAL.
- GEVAL: ram_state 01/10 -> game_over=1, winner=ram_state. Then FINISH.
- FINISH:
  - done=1 for one cycle.
  - Toggle player.
  - forced_macro = closed_mask_next[u-1] ? 0 : u.
  - If game_over still 0 and closed_mask_next=all ones -> game_over=1, winner=11.
  - Then IDLE.
- Latency, counted from the edge sampling start:
  - done in cycle 6 without a macro win, cycle 9 with one.
  - invalid in cycle 3 for a rule reject, cycle 1 for a game_over reject.
- A draw in a macro is never written to macro 0.
- Reset mid-operation aborts immediately. A WRITE interrupted before the edge leaves the RAM unchanged.

Test Plan:
- Reset, then start m=5 u=1 -> ram write (5,1)=01 in cycle 3; done at cycle 6; player=10, forced_macro=1.
- Next start m=3 u=2 while forced_macro=1 -> invalid pulse at cycle 3, no ram_we; player stays 10, forced_macro stays 1.
- Occupied cell: play (1,5) then request (1,5) again with forced_macro=1 -> invalid; RAM unchanged.
- P1 completes micros 1,2,3 in macro 4 -> EVAL sees 01, closed_mask=000001000, RAM(0,4)=01, done at cycle 9. A later move with u=4 -> forced_macro=0.
- P1 wins macros 1,5,9 -> GEVAL 01: game_over=1, winner=01. Any further start -> invalid at cycle 1.
- new_game in IDLE -> ram_clear single pulse, player=01, closed_mask=0, game_over=0. clear_n low during WRITE -> ram_we drops asynchronously, busy=0.

Source files
------------

// File: rtl/move_controller_if.sv
// Board RAM bus seen from the move controller: address/write/clear towards
// the RAM, registered read data and macro result back.
`timescale 1ns/1ps

interface move_controller_if;
    logic [1:0] ram_q;
    logic [1:0] ram_state;
    logic       ram_we;
    logic [1:0] ram_data;
    logic [3:0] ram_addr_macro;
    logic [3:0] ram_addr_micro;
    logic       ram_clear;

    modport master (
        input  ram_q, ram_state,
        output ram_we, ram_data, ram_addr_macro, ram_addr_micro, ram_clear
    );

    modport slave (
        output ram_q, ram_state,
        input  ram_we, ram_data, ram_addr_macro, ram_addr_micro, ram_clear
    );
endinterface

// File: rtl/move_controller.sv
// Ultimate tic-tac-toe move sequencer: validates one (macro, micro) request,
// writes it to the board RAM, propagates macro wins to the global board.
`timescale 1ns/1ps

module move_controller (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     start,
    input  logic                     new_game,
    input  logic [3:0]               macro_in,
    input  logic [3:0]               micro_in,
    move_controller_if.master        ram,
    output logic [1:0]               player,
    output logic [3:0]               forced_macro,
    output logic [8:0]               closed_mask,
    output logic                     busy,
    output logic                     done,
    output logic                     invalid,
    output logic                     game_over,
    output logic [1:0]               winner
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_CHECK, S_REJECT, S_WRITE, S_WAIT,
        S_EVAL, S_GWRITE, S_GWAIT, S_GEVAL, S_FINISH
    } state_e;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] P1   = 2'b01;
    localparam logic [1:0] P2   = 2'b10;
    localparam logic [1:0] DRAW = 2'b11;

    state_e     state_q, state_d;
    logic [3:0] m_q, m_d, u_q, u_d;
    logic [1:0] player_q, player_d;
    logic [3:0] forced_q, forced_d;
    logic [8:0] closed_mask_q, closed_mask_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] macro_win_q, macro_win_d;
    logic       ram_we_q, ram_we_d;
    logic [1:0] ram_data_q, ram_data_d;
    logic [3:0] addr_macro_q, addr_macro_d;
    logic [3:0] addr_micro_q, addr_micro_d;
    logic       ram_clear_q, ram_clear_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       invalid_q, invalid_d;

    logic [8:0] m_onehot, u_onehot;
    logic       move_bad;
    logic       g_phase;

    // One-hot cell select; all zero for anything outside 1..9.
    function automatic logic [8:0] cell_bit(input logic [3:0] idx);
        cell_bit = '0;
        if (idx >= 4'd1 && idx <= 4'd9)
            cell_bit[idx - 4'd1] = 1'b1;
    endfunction

    always_comb begin
        m_onehot = cell_bit(m_q);
        u_onehot = cell_bit(u_q);
        move_bad = (m_onehot == '0) || (u_onehot == '0)
                || (forced_q != 4'd0 && m_q != forced_q)
                || ((closed_mask_q & m_onehot) != '0)
                || (ram.ram_q != NONE);
    end

    always_comb begin
        // NOTE: every *_d gets a default first, so no path through the case
        // can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        m_d           = m_q;
        u_d           = u_q;
        player_d      = player_q;
        forced_d      = forced_q;
        closed_mask_d = closed_mask_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        macro_win_d   = macro_win_q;
        ram_clear_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (new_game) begin
                    ram_clear_d   = 1'b1;
                    player_d      = P1;
                    forced_d      = 4'd0;
                    closed_mask_d = '0;
                    game_over_d   = 1'b0;
                    winner_d      = NONE;
                    m_d           = 4'd0;
                    u_d           = 4'd0;
                end else if (start) begin
                    if (game_over_q) begin
                        state_d = S_REJECT;
                    end else begin
                        m_d     = macro_in;
                        u_d     = micro_in;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK:  state_d = move_bad ? S_REJECT : S_WRITE;
            S_REJECT: state_d = S_IDLE;
            S_WRITE:  state_d = S_WAIT;
            S_WAIT:   state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_FINISH;
                if (ram.ram_state != NONE)
                    closed_mask_d = closed_mask_q | m_onehot;
                if (ram.ram_state == P1 || ram.ram_state == P2) begin
                    macro_win_d = ram.ram_state;
                    state_d     = S_GWRITE;
                end
            end
            S_GWRITE: state_d = S_GWAIT;
            S_GWAIT:  state_d = S_GEVAL;
            S_GEVAL: begin
                if (ram.ram_state == P1 || ram.ram_state == P2) begin
                    game_over_d = 1'b1;
                    winner_d    = ram.ram_state;
                end
                state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Move bookkeeping lands together with the done pulse, so status
        // outputs already show the next move's constraints when done is seen.
        done_d = (state_d == S_FINISH);
        if (done_d) begin
            player_d = (player_q == P1) ? P2 : P1;
            forced_d = ((closed_mask_d & u_onehot) != '0) ? 4'd0 : u_q;
            if (!game_over_d && (&closed_mask_d)) begin
                game_over_d = 1'b1;
                winner_d    = DRAW;
            end
        end

        invalid_d = (state_d == S_REJECT);
        busy_d    = (state_d != S_IDLE);
        ram_we_d  = (state_d == S_WRITE) || (state_d == S_GWRITE);

        ram_data_d = ram_data_q;
        if (state_d == S_WRITE)
            ram_data_d = player_q;
        else if (state_d == S_GWRITE)
            ram_data_d = macro_win_d;

        // Global-board phase addresses macro 0 with the won macro as cell.
        g_phase = (state_d == S_GWRITE) || (state_d == S_GWAIT) || (state_d == S_GEVAL);
        addr_macro_d = g_phase ? 4'd0 : m_d;
        addr_micro_d = g_phase ? m_d  : u_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= S_IDLE;
            m_q           <= 4'd0;
            u_q           <= 4'd0;
            player_q      <= P1;
            forced_q      <= 4'd0;
            closed_mask_q <= '0;
            game_over_q   <= 1'b0;
            winner_q      <= NONE;
            macro_win_q   <= NONE;
            ram_we_q      <= 1'b0;
            ram_data_q    <= 2'b00;
            addr_macro_q  <= 4'd0;
            addr_micro_q  <= 4'd0;
            ram_clear_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            invalid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_q           <= m_d;
            u_q           <= u_d;
            player_q      <= player_d;
            forced_q      <= forced_d;
            closed_mask_q <= closed_mask_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            macro_win_q   <= macro_win_d;
            ram_we_q      <= ram_we_d;
            ram_data_q    <= ram_data_d;
            addr_macro_q  <= addr_macro_d;
            addr_micro_q  <= addr_micro_d;
            ram_clear_q   <= ram_clear_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            invalid_q     <= invalid_d;
        end
    end

    assign ram.ram_we         = ram_we_q;
    assign ram.ram_data       = ram_data_q;
    assign ram.ram_addr_macro = addr_macro_q;
    assign ram.ram_addr_micro = addr_micro_q;
    assign ram.ram_clear      = ram_clear_q;
    assign player             = player_q;
    assign forced_macro       = forced_q;
    assign closed_mask        = closed_mask_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign invalid            = invalid_q;
    assign game_over          = game_over_q;
    assign winner             = winner_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: behavioural board RAM, a rule-level game model,
// a hand-checked vector table, scripted games and random play.
`timescale 1ns/1ps

module tb_move_controller;

    typedef logic [8:0][1:0] cells_t;   // cells_t[k-1] = micro cell k

    typedef struct {
        logic [3:0] m;
        logic [3:0] u;
        bit         ok;
        int         cyc;
        logic [1:0] pl;
        logic [3:0] fm;
    } vec_t;

    localparam int WIN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       start = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] macro_in = 4'd0;
    logic [3:0] micro_in = 4'd0;
    logic [1:0] player, winner;
    logic [3:0] forced_macro;
    logic [8:0] closed_mask;
    logic       busy, done, invalid, game_over;

    move_controller_if bus();

    move_controller dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .start        (start),
        .new_game     (new_game),
        .macro_in     (macro_in),
        .micro_in     (micro_in),
        .ram          (bus),
        .player       (player),
        .forced_macro (forced_macro),
        .closed_mask  (closed_mask),
        .busy         (busy),
        .done         (done),
        .invalid      (invalid),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] result_of(input cells_t c);
        bit full;
        full = 1'b1;
        result_of = 2'b00;
        for (int k = 0; k < 9; k++)
            if (c[k] == 2'b00) full = 1'b0;
        for (int l = 0; l < 8; l++)
            if (c[WIN[l][0]] != 2'b00 && c[WIN[l][0]] == c[WIN[l][1]] && c[WIN[l][1]] == c[WIN[l][2]])
                result_of = c[WIN[l][0]];
        if (result_of == 2'b00 && full) result_of = 2'b11;
    endfunction

    // Board RAM: registered read, write on the edge, combinational macro result.
    cells_t ram_mem [0:9];

    always @(posedge clk) begin
        if (bus.ram_clear) begin
            for (int i = 0; i < 10; i++) ram_mem[i] <= '0;
        end else if (bus.ram_we && bus.ram_addr_macro <= 4'd9
                     && bus.ram_addr_micro >= 4'd1 && bus.ram_addr_micro <= 4'd9) begin
            ram_mem[int'(bus.ram_addr_macro)][int'(bus.ram_addr_micro) - 1] <= bus.ram_data;
        end
        if (bus.ram_addr_macro <= 4'd9 && bus.ram_addr_micro >= 4'd1 && bus.ram_addr_micro <= 4'd9)
            bus.ram_q <= ram_mem[int'(bus.ram_addr_macro)][int'(bus.ram_addr_micro) - 1];
        else
            bus.ram_q <= 2'b00;
    end

    always_comb begin
        bus.ram_state = 2'b00;
        if (bus.ram_addr_macro <= 4'd9)
            bus.ram_state = result_of(ram_mem[int'(bus.ram_addr_macro)]);
    end

    // Game model: the rules applied directly to a board array.
    cells_t     mdl_board [0:9];
    bit         mdl_closed [1:9];
    logic [1:0] mdl_player;
    logic [3:0] mdl_forced;
    bit         mdl_over;
    logic [1:0] mdl_winner;

    task automatic mdl_new_game();
        for (int i = 0; i < 10; i++) mdl_board[i] = '0;
        for (int k = 1; k <= 9; k++) mdl_closed[k] = 1'b0;
        mdl_player = 2'b01;
        mdl_forced = 4'd0;
        mdl_over   = 1'b0;
        mdl_winner = 2'b00;
    endtask

    function automatic bit mdl_legal(input logic [3:0] m, input logic [3:0] u);
        if (m < 4'd1 || m > 4'd9 || u < 4'd1 || u > 4'd9) return 1'b0;
        if (mdl_forced != 4'd0 && m != mdl_forced) return 1'b0;
        if (mdl_closed[m]) return 1'b0;
        return mdl_board[m][u - 4'd1] == 2'b00;
    endfunction

    function automatic logic [8:0] mdl_mask();
        mdl_mask = '0;
        for (int k = 1; k <= 9; k++) mdl_mask[k - 1] = mdl_closed[k];
    endfunction

    function automatic int ram_diffs();
        ram_diffs = 0;
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 9; k++)
                if (ram_mem[i][k] !== mdl_board[i][k]) ram_diffs++;
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_player"}, player, mdl_player);
        check({tag, "_forced"}, forced_macro, mdl_forced);
        check({tag, "_mask"}, closed_mask, mdl_mask());
        check({tag, "_game_over"}, game_over, mdl_over);
        check({tag, "_winner"}, winner, mdl_winner);
        check({tag, "_ram"}, ram_diffs(), 0);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        start    = 1'($urandom_range(0, 1));
        macro_in = 4'($urandom_range(1, 9));
        micro_in = 4'($urandom_range(1, 9));
        @(negedge clk);
        new_game = 1'b0;
        start    = 1'b0;
        check("ng_clear_pulse", bus.ram_clear, 1'b1);
        check("ng_busy", busy, 1'b0);
        @(negedge clk);
        check("ng_clear_width", bus.ram_clear, 1'b0);
        mdl_new_game();
        check_status("ng");
    endtask

    // One request: predict with the model, drive, observe, compare.
    task automatic do_req(input logic [3:0] m, input logic [3:0] u, input bit hold,
                          output bit got_ok, output int got_cyc);
        bit         exp_ok, hold_eff, seen;
        int         exp_cyc, exp_writes, n_we, w1_cyc, w2_cyc;
        logic [3:0] w1_m, w1_u, w2_m, w2_u;
        logic [1:0] w1_d, w2_d, exp_d, r, g;

        hold_eff   = hold && !mdl_over;
        exp_writes = 0;
        exp_d      = mdl_player;
        r          = 2'b00;
        if (mdl_over) begin
            exp_ok = 1'b0; exp_cyc = 1;
        end else if (!mdl_legal(m, u)) begin
            exp_ok = 1'b0; exp_cyc = 3;
        end else begin
            exp_ok = 1'b1; exp_cyc = 6; exp_writes = 1;
            mdl_board[m][u - 4'd1] = mdl_player;
            r = result_of(mdl_board[m]);
            if (r != 2'b00) mdl_closed[m] = 1'b1;
            if (r == 2'b01 || r == 2'b10) begin
                exp_cyc = 9; exp_writes = 2;
                mdl_board[0][m - 4'd1] = r;
                g = result_of(mdl_board[0]);
                if (g == 2'b01 || g == 2'b10) begin
                    mdl_over = 1'b1; mdl_winner = g;
                end
            end
            mdl_forced = mdl_closed[u] ? 4'd0 : u;
            mdl_player = (mdl_player == 2'b01) ? 2'b10 : 2'b01;
            if (!mdl_over && mdl_mask() == 9'h1FF) begin
                mdl_over = 1'b1; mdl_winner = 2'b11;
            end
        end

        @(negedge clk);
        start = 1'b1; macro_in = m; micro_in = u;
        @(negedge clk);
        seen = 1'b0; got_ok = 1'b0; got_cyc = 0; n_we = 0;
        w1_m = 0; w1_u = 0; w1_d = 0; w1_cyc = 0; w2_m = 0; w2_u = 0; w2_d = 0; w2_cyc = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin
                check("busy_cycle1", busy, 1'b1);
                if (hold_eff) begin
                    macro_in = ~m; micro_in = ~u;
                end else begin
                    start = 1'b0;
                end
            end
            if (k == 4) start = 1'b0;
            if (bus.ram_we) begin
                if (n_we == 0) begin
                    w1_m = bus.ram_addr_macro; w1_u = bus.ram_addr_micro; w1_d = bus.ram_data; w1_cyc = k;
                end else begin
                    w2_m = bus.ram_addr_macro; w2_u = bus.ram_addr_micro; w2_d = bus.ram_data; w2_cyc = k;
                end
                n_we++;
            end
            if (done || invalid) begin
                seen = 1'b1; got_ok = done; got_cyc = k;
            end
        end
        start = 1'b0;
        check("response_seen", seen, 1'b1);
        check("accepted", got_ok, exp_ok);
        check("latency", got_cyc, exp_cyc);
        check("write_count", n_we, exp_writes);
        if (exp_writes >= 1)
            check("write_move", {w1_m, w1_u, w1_d, 8'(w1_cyc)}, {m, u, exp_d, 8'd3});
        if (exp_writes == 2)
            check("write_global", {w2_m, w2_u, w2_d, 8'(w2_cyc)}, {4'd0, m, r, 8'd6});
        @(negedge clk);
        check("back_to_idle", {busy, done, invalid}, 3'b000);
        check_status("req");
    endtask

    vec_t vecs [9];
    int   gs_m [19] = '{1,5,1,9,1,2,5,5,3,4,5,4,5,6,9,7,9,3,9};
    int   gs_u [19] = '{5,1,9,1,1,1,5,3,1,1,4,5,6,1,5,1,3,9,7};

    initial begin
        bit         ok;
        int         cyc;
        logic [3:0] rm, ru;
        logic [7:0] legal_q [$];

        vecs[0] = '{4'd5, 4'd1,  1'b1, 6, 2'b10, 4'd1};
        vecs[1] = '{4'd3, 4'd2,  1'b0, 3, 2'b10, 4'd1};
        vecs[2] = '{4'd1, 4'd5,  1'b1, 6, 2'b01, 4'd5};
        vecs[3] = '{4'd5, 4'd2,  1'b1, 6, 2'b10, 4'd2};
        vecs[4] = '{4'd2, 4'd1,  1'b1, 6, 2'b01, 4'd1};
        vecs[5] = '{4'd1, 4'd5,  1'b0, 3, 2'b01, 4'd1};
        vecs[6] = '{4'd1, 4'd10, 1'b0, 3, 2'b01, 4'd1};
        vecs[7] = '{4'd1, 4'd0,  1'b0, 3, 2'b01, 4'd1};
        vecs[8] = '{4'd1, 4'd3,  1'b1, 6, 2'b10, 4'd3};

        // Reset values while clear_n is held low.
        #12;
        check("rst_player", player, 2'b01);
        check("rst_forced", forced_macro, 4'd0);
        check("rst_mask", closed_mask, 9'd0);
        check("rst_flags", {busy, done, invalid, game_over, bus.ram_we, bus.ram_clear}, 6'd0);
        check("rst_winner", winner, 2'b00);
        check("rst_addr", {bus.ram_addr_macro, bus.ram_addr_micro}, 8'd0);
        @(negedge clk);
        clear_n = 1'b1;
        do_new_game();

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].m, vecs[i].u, 1'b0, ok, cyc);
            check($sformatf("vec%0d_ok", i), ok, vecs[i].ok);
            check($sformatf("vec%0d_cyc", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_player", i), player, vecs[i].pl);
            check($sformatf("vec%0d_forced", i), forced_macro, vecs[i].fm);
        end
        check("vec_ram_5_1", ram_mem[5][0], 2'b01);
        check("vec_ram_1_5", ram_mem[1][4], 2'b10);

        // P1 takes macro 4 with micros 1,2,3.
        do_new_game();
        do_req(4'd4, 4'd1, 1'b0, ok, cyc);
        do_req(4'd1, 4'd4, 1'b0, ok, cyc);
        do_req(4'd4, 4'd2, 1'b0, ok, cyc);
        do_req(4'd2, 4'd4, 1'b1, ok, cyc);
        do_req(4'd4, 4'd3, 1'b0, ok, cyc);
        check("m4_win_cyc", cyc, 9);
        check("m4_mask", closed_mask, 9'b000001000);
        check("m4_global_cell", ram_mem[0][3], 2'b01);
        check("m4_forced", forced_macro, 4'd3);
        do_req(4'd3, 4'd4, 1'b0, ok, cyc);
        check("m4_sent_free", forced_macro, 4'd0);

        // P1 wins macros 1, 5, 9 and with them the global diagonal.
        do_new_game();
        for (int i = 0; i < 19; i++) begin
            do_req(4'(gs_m[i]), 4'(gs_u[i]), 1'b0, ok, cyc);
            check($sformatf("game_mv%0d_ok", i + 1), ok, 1'b1);
            check($sformatf("game_mv%0d_cyc", i + 1), cyc, (i == 4 || i == 12 || i == 18) ? 9 : 6);
        end
        check("game_over_flag", game_over, 1'b1);
        check("game_winner", winner, 2'b01);
        check("game_mask", closed_mask, 9'b100010001);
        do_req(4'd7, 4'd7, 1'b1, ok, cyc);
        check("over_reject_cyc", cyc, 1);
        check("over_reject_ok", ok, 1'b0);
        do_new_game();
        check("ng_player_after_game", player, 2'b01);

        // Random play, mostly legal moves with some junk requests.
        for (int n = 0; n < 400; n++) begin
            if (mdl_over) begin
                if ($urandom_range(0, 1) == 1)
                    do_req(4'($urandom_range(1, 9)), 4'($urandom_range(1, 9)), 1'b0, ok, cyc);
                do_new_game();
                continue;
            end
            legal_q.delete();
            for (int mm = 1; mm <= 9; mm++)
                for (int uu = 1; uu <= 9; uu++)
                    if (mdl_legal(4'(mm), 4'(uu))) legal_q.push_back({4'(mm), 4'(uu)});
            if ($urandom_range(0, 9) < 7 && legal_q.size() > 0) begin
                {rm, ru} = legal_q[$urandom_range(0, legal_q.size() - 1)];
            end else begin
                rm = 4'($urandom_range(0, 11));
                ru = 4'($urandom_range(0, 11));
            end
            do_req(rm, ru, ($urandom_range(0, 4) == 0), ok, cyc);
        end

        // Reset asserted during WRITE: ram_we drops at once, RAM untouched.
        do_new_game();
        @(negedge clk);
        start = 1'b1; macro_in = 4'd5; micro_in = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wr_we_before_reset", bus.ram_we, 1'b1);
        #1 clear_n = 1'b0;
        #1;
        check("wr_we_async_drop", bus.ram_we, 1'b0);
        check("wr_busy_async_drop", busy, 1'b0);
        @(negedge clk);
        clear_n = 1'b1;
        mdl_player = 2'b01; mdl_forced = 4'd0; mdl_over = 1'b0; mdl_winner = 2'b00;
        for (int k = 1; k <= 9; k++) mdl_closed[k] = 1'b0;
        check("wr_cell_untouched", ram_mem[5][4], 2'b00);
        check_status("post_reset");
        do_req(4'd5, 4'd5, 1'b0, ok, cyc);
        check("post_reset_move", ok, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
